control_path: RTL and testbench

Sequencing controller for the Ascon-AEAD128 core's data path. It accepts a start request, then steps the permutation one round per cycle, absorbing associated-data (AD) and data blocks through valid/ready handshakes. It drives every data-path select and enable, and flags output ciphertext/plaintext blocks and the final tag. It sits beside the data path inside `ascon_aead128_core`; blocks arrive already padded to 128 bits.

---
 rtl/ascon_aead128_pkg.sv | 26 ++
 rtl/control_path_round_counter.sv | 40 ++++
 rtl/control_path.sv | 212 +++++++++++++++++++++
 tb/tb_control_path.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the Ascon-AEAD128 core.
// Holds the round index type, the control-path state encoding, the round
// boundaries of the p12/p8 permutations and the key XOR select codes.
package ascon_aead128_pkg;

  typedef logic [3:0] round;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_INIT  = 3'd1,
    CTRL_AD    = 3'd2,
    CTRL_DATA  = 3'd3,
    CTRL_FINAL = 3'd4
  } ctrl_state;

  localparam round ROUND_P12_FIRST = 4'd0;
  localparam round ROUND_P8_FIRST  = 4'd4;
  localparam round ROUND_LAST      = 4'd11;

  // Key XOR codes: LOW puts the key into s3..s4, HIGH into s2..s3.
  localparam logic [1:0] KEY_XOR_NONE = 2'b00;
  localparam logic [1:0] KEY_XOR_LOW  = 2'b01;
  localparam logic [1:0] KEY_XOR_HIGH = 2'b10;
  localparam logic [1:0] KEY_XOR_BOTH = 2'b11;

endpackage

// File: rtl/control_path_round_counter.sv
// Permutation round counter. Loads the first round of p12 (0) or p8 (4),
// increments while enabled, holds otherwise, and flags the last round (11),
// which is the absorb cycle for the controller.
module round_counter
  import ascon_aead128_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_p8,
  input  logic inc,
  output round rnd,
  output logic last
);

  round rnd_q, rnd_d;

  // Load has priority over increment; otherwise the count holds.
  always_comb begin
    rnd_d = rnd_q;
    if (load) begin
      rnd_d = load_p8 ? ROUND_P8_FIRST : ROUND_P12_FIRST;
    end else if (inc) begin
      rnd_d = rnd_q + round'(1);
    end
  end

  // Round register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= ROUND_P12_FIRST;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign rnd  = rnd_q;
  assign last = (rnd_q == ROUND_LAST);

endmodule

// File: rtl/control_path.sv
// Sequencing controller for the Ascon-AEAD128 data path.
// Steps the permutation one round per cycle and absorbs AD/data blocks on
// the last round of each permutation through same-cycle valid/ready.
// Optional feature: define ASCON_ABORT_EN to add an `abort` input that
// drops any running operation back to IDLE.
//
// state      | meaning
// -----------+------------------------------------------------------------
// CTRL_IDLE  | waiting for start; data path selects the fresh init state
// CTRL_INIT  | p12 initialisation; round 11 absorbs first AD or data block
// CTRL_AD    | p8 after an AD block; round 11 absorbs next AD or first data
// CTRL_DATA  | p8 after a data block; round 11 absorbs the next data block
// CTRL_FINAL | p12 finalisation; round 11 presents the tag
module control_path
  import ascon_aead128_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ad_en,
  input  logic       ad_valid,
  input  logic       ad_last,
  input  logic       db_valid,
  input  logic       db_last,
`ifdef ASCON_ABORT_EN
  input  logic       abort,
`endif
  output logic       ad_ready,
  output logic       db_ready,
  output logic       dout_valid,
  output logic       tag_valid,
  output logic       busy,
  output round       rnd,
  output logic       en_internal,
  output logic       en_new_aead,
  output logic       sel_state,
  output logic       sel_din,
  output logic       sel_dout,
  output logic       sel_xor_data,
  output logic       end_ad,
  output logic [1:0] sel_xor_key
);

  ctrl_state state_q, state_d;
  logic      ad_en_q, ad_en_d;
  logic      ad_last_q, ad_last_d;
  logic      cnt_load, cnt_load_p8, cnt_inc;
  logic      rnd_last;
  logic      take_ad, take_data;

  round_counter u_round_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_p8 (cnt_load_p8),
    .inc     (cnt_inc),
    .rnd     (rnd),
    .last    (rnd_last)
  );

  // State, AD-enable and "previous AD block was last" registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CTRL_IDLE;
      ad_en_q   <= 1'b0;
      ad_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ad_en_q   <= ad_en_d;
      ad_last_q <= ad_last_d;
    end
  end

  // Next-state and output decode; absorb cycles share the AD/data handling
  // below the case so the stall behaviour is identical in every state.
  always_comb begin
    state_d      = state_q;
    ad_en_d      = ad_en_q;
    ad_last_d    = ad_last_q;
    cnt_load     = 1'b0;
    cnt_load_p8  = 1'b0;
    cnt_inc      = 1'b0;
    take_ad      = 1'b0;
    take_data    = 1'b0;
    ad_ready     = 1'b0;
    db_ready     = 1'b0;
    dout_valid   = 1'b0;
    tag_valid    = 1'b0;
    busy         = 1'b1;
    en_internal  = 1'b0;
    en_new_aead  = 1'b0;
    sel_state    = 1'b0;
    sel_din      = 1'b0;
    sel_dout     = 1'b0;
    sel_xor_data = 1'b0;
    end_ad       = 1'b0;
    sel_xor_key  = KEY_XOR_NONE;

    case (state_q)
      CTRL_IDLE: begin
        busy      = 1'b0;
        sel_state = 1'b1;
        if (start) begin
          en_internal = 1'b1;
          en_new_aead = 1'b1;
          ad_en_d     = ad_en;
          ad_last_d   = 1'b0;
          cnt_load    = 1'b1;
          state_d     = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        if (!rnd_last) begin
          en_internal = 1'b1;
          cnt_inc     = 1'b1;
        end else begin
          sel_xor_key[0] = 1'b1;
          if (ad_en_q) begin
            take_ad = 1'b1;
          end else begin
            end_ad    = 1'b1;
            take_data = 1'b1;
          end
        end
      end
      CTRL_AD: begin
        if (!rnd_last) begin
          en_internal = 1'b1;
          cnt_inc     = 1'b1;
        end else if (ad_last_q) begin
          end_ad    = 1'b1;
          take_data = 1'b1;
        end else begin
          take_ad = 1'b1;
        end
      end
      CTRL_DATA: begin
        if (!rnd_last) begin
          en_internal = 1'b1;
          cnt_inc     = 1'b1;
        end else begin
          take_data = 1'b1;
        end
      end
      CTRL_FINAL: begin
        en_internal = 1'b1;
        if (!rnd_last) begin
          cnt_inc = 1'b1;
        end else begin
          sel_xor_key = KEY_XOR_LOW;
          sel_dout    = 1'b1;
          tag_valid   = 1'b1;
          cnt_load    = 1'b1;
          state_d     = CTRL_IDLE;
        end
      end
      default: begin
        cnt_load = 1'b1;
        state_d  = CTRL_IDLE;
      end
    endcase

    // Selects are driven even while stalled so the data path sees a stable
    // pending absorb; only the enable and handshakes wait for valid.
    if (take_ad) begin
      sel_xor_data = 1'b1;
      if (ad_valid) begin
        ad_ready    = 1'b1;
        en_internal = 1'b1;
        ad_last_d   = ad_last;
        cnt_load    = 1'b1;
        cnt_load_p8 = 1'b1;
        state_d     = CTRL_AD;
      end
    end

    if (take_data) begin
      sel_din      = 1'b1;
      sel_xor_data = 1'b1;
      if (db_last) begin
        sel_xor_key[1] = 1'b1;
      end
      if (db_valid) begin
        db_ready    = 1'b1;
        dout_valid  = 1'b1;
        en_internal = 1'b1;
        cnt_load    = 1'b1;
        cnt_load_p8 = !db_last;
        state_d     = db_last ? CTRL_FINAL : CTRL_DATA;
      end
    end

`ifdef ASCON_ABORT_EN
    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_d     = CTRL_IDLE;
      ad_en_d     = ad_en_q;
      ad_last_d   = ad_last_q;
      cnt_load    = 1'b1;
      cnt_load_p8 = 1'b0;
      cnt_inc     = 1'b0;
      en_internal = 1'b0;
      en_new_aead = 1'b0;
      ad_ready    = 1'b0;
      db_ready    = 1'b0;
      dout_valid  = 1'b0;
      tag_valid   = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_control_path.sv
// Directed-vector bench for control_path. Each vector holds the inputs for
// one cycle and the full expected output word, compared mid-cycle.
module tb_control_path;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, ad_en, ad_valid, ad_last, db_valid, db_last;
`ifdef ASCON_ABORT_EN
  logic       abort;
`endif
  logic       ad_ready, db_ready, dout_valid, tag_valid, busy;
  logic [3:0] rnd;
  logic       en_internal, en_new_aead, sel_state, sel_din, sel_dout;
  logic       sel_xor_data, end_ad;
  logic [1:0] sel_xor_key;

  always #5 clk = ~clk;

  control_path dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ad_en        (ad_en),
    .ad_valid     (ad_valid),
    .ad_last      (ad_last),
    .db_valid     (db_valid),
    .db_last      (db_last),
`ifdef ASCON_ABORT_EN
    .abort        (abort),
`endif
    .ad_ready     (ad_ready),
    .db_ready     (db_ready),
    .dout_valid   (dout_valid),
    .tag_valid    (tag_valid),
    .busy         (busy),
    .rnd          (rnd),
    .en_internal  (en_internal),
    .en_new_aead  (en_new_aead),
    .sel_state    (sel_state),
    .sel_din      (sel_din),
    .sel_dout     (sel_dout),
    .sel_xor_data (sel_xor_data),
    .end_ad       (end_ad),
    .sel_xor_key  (sel_xor_key)
  );

  // Output word: {ad_ready, db_ready, dout_valid, tag_valid, busy, rnd,
  //               en_internal, en_new_aead, sel_state, sel_din, sel_dout,
  //               sel_xor_data, end_ad, sel_xor_key}
  logic [17:0] obs;
  assign obs = {ad_ready, db_ready, dout_valid, tag_valid, busy, rnd,
                en_internal, en_new_aead, sel_state, sel_din, sel_dout,
                sel_xor_data, end_ad, sel_xor_key};

  localparam logic [17:0] ADR  = 18'h20000;
  localparam logic [17:0] DBR  = 18'h10000;
  localparam logic [17:0] DV   = 18'h08000;
  localparam logic [17:0] TV   = 18'h04000;
  localparam logic [17:0] BSY  = 18'h02000;
  localparam logic [17:0] EN   = 18'h00100;
  localparam logic [17:0] NEW  = 18'h00080;
  localparam logic [17:0] SST  = 18'h00040;
  localparam logic [17:0] DIN  = 18'h00020;
  localparam logic [17:0] DOUT = 18'h00010;
  localparam logic [17:0] XD   = 18'h00008;
  localparam logic [17:0] EAD  = 18'h00004;
  localparam logic [17:0] K01  = 18'h00001;
  localparam logic [17:0] K10  = 18'h00002;
  localparam logic [17:0] K11  = 18'h00003;

  // Input word: {abort, start, ad_en, ad_valid, ad_last, db_valid, db_last}
  localparam logic [6:0] AB  = 7'h40;
  localparam logic [6:0] ST  = 7'h20;
  localparam logic [6:0] ADE = 7'h10;
  localparam logic [6:0] ADV = 7'h08;
  localparam logic [6:0] ADL = 7'h04;
  localparam logic [6:0] DBV = 7'h02;
  localparam logic [6:0] DBL = 7'h01;
  localparam logic [6:0] NONE = 7'h00;

  typedef struct {
    logic [6:0]  in;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [17:0] R(input int r);
    return 18'(r) << 9;
  endfunction

  task automatic drive(input logic [6:0] in);
`ifdef ASCON_ABORT_EN
    abort = in[6];
`endif
    start    = in[5];
    ad_en    = in[4];
    ad_valid = in[3];
    ad_last  = in[2];
    db_valid = in[1];
    db_last  = in[0];
  endtask

  task automatic check(input string name, input int idx, input logic [17:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: outputs got %h expected %h", name, idx, obs, exp);
    end
  endtask

  task automatic add(input logic [6:0] in, input logic [17:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic add_rounds(input int first, input int n, input logic [6:0] in);
    for (int i = 0; i < n; i++) add(in, BSY | EN | R(first + i));
  endtask

  // Applies every vector one cycle each; entered and left at posedge+1.
  task automatic run(input string name);
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #2;
      check(name, i, tbl[i].exp);
      @(posedge clk);
      #1;
    end
    drive(NONE);
    tbl.delete();
  endtask

  // Minimum operation: no AD, one last data block valid throughout.
  task automatic build_min();
    add(ST | DBV | DBL, SST | EN | NEW);
    add_rounds(0, 11, DBV | DBL);
    add(DBV | DBL, BSY | R(11) | EN | EAD | DIN | XD | DBR | DV | K11);
    add_rounds(0, 11, DBV | DBL);
    add(DBV | DBL, BSY | R(11) | EN | TV | DOUT | K01);
    add(NONE, SST);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NONE);
    #12;
    check("reset_state", 0, SST);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 0, SST);

    build_min();
    run("min_op");

    // Two AD blocks then two data blocks; the other channel's valid is
    // raised at absorbs where it must be ignored.
    add(ST | ADE, SST | EN | NEW);
    add_rounds(0, 11, NONE);
    add(ADV, BSY | R(11) | EN | K01 | XD | ADR);
    add_rounds(4, 7, NONE);
    add(ADV | ADL | DBV, BSY | R(11) | EN | XD | ADR);
    add_rounds(4, 7, NONE);
    add(DBV, BSY | R(11) | EN | EAD | DIN | XD | DBR | DV);
    add_rounds(4, 7, NONE);
    add(DBV | DBL | ADV, BSY | R(11) | EN | DIN | XD | DBR | DV | K10);
    add_rounds(0, 11, NONE);
    add(NONE, BSY | R(11) | EN | TV | DOUT | K01);
    add(NONE, SST);
    run("ad2_db2");

    // Data stall for 3 cycles at a DATA absorb cycle.
    add(ST, SST | EN | NEW);
    add_rounds(0, 11, NONE);
    add(DBV, BSY | R(11) | EN | EAD | DIN | XD | DBR | DV | K01);
    add_rounds(4, 7, NONE);
    for (int i = 0; i < 3; i++) add(DBL, BSY | R(11) | DIN | XD | K10);
    add(DBV | DBL, BSY | R(11) | EN | DIN | XD | DBR | DV | K10);
    add_rounds(0, 11, NONE);
    add(NONE, BSY | R(11) | EN | TV | DOUT | K01);
    add(NONE, SST);
    run("db_stall");

    // Start during FINAL is ignored; start right after the tag is taken,
    // then the new operation runs into AD.
    build_min();
    tbl[18].in = tbl[18].in | ST;
    tbl[25].in = ST | ADE;
    tbl[25].exp = SST | EN | NEW;
    add_rounds(0, 11, NONE);
    add(ADV, BSY | R(11) | EN | K01 | XD | ADR);
    add(NONE, BSY | EN | R(4));
    run("restart");

    // Asynchronous reset while in AD.
    rst_n = 1'b0;
    #2;
    check("reset_mid_ad", 0, SST);
    @(posedge clk);
    #1;
    check("reset_mid_ad", 1, SST);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_ad", 2, SST);

`ifdef ASCON_ABORT_EN
    add(ST, SST | EN | NEW);
    add_rounds(0, 5, NONE);
    add(AB, BSY | R(5));
    add(NONE, SST);
    add(AB | ST, SST);
    add(NONE, SST);
    run("abort");
    build_min();
    run("after_abort");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
